// File: rtl/vga_stream_sink.sv
// vga_stream_sink: consumes {rgb, frame_start} words and replays them on a free-running VGA raster.
// Latency: a pushed word reaches the FIFO head 1 clk later; hsync/vsync/rgb register on the pixel tick.
// Backpressure: si_ready = !full; drains one word per clk while seeking, one per visible tick in RUN.
// Ports: clk, reset (sync, active-high); si_data/si_valid/si_ready stream input, si_data[0] = frame_start;
//        err_clr clears the sticky underflow/misalign flags; hsync/vsync active-low; rgb blanked to 0;
//        locked high while replaying. Raster geometry parameters default to 640x480 @ 800x525.

// Small first-word-fall-through FIFO: head_dat shows the oldest word whenever !empty.
module vga_stream_sink_fifo #(
  parameter int W  = 13,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
endmodule

module vga_stream_sink #(
  parameter int CD      = 12,
  parameter int DIV     = 4,
  parameter int FIFO_AW = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CD:0]   si_data,
  input  logic          si_valid,
  output logic          si_ready,
  input  logic          err_clr,
  output logic          hsync,
  output logic          vsync,
  output logic [CD-1:0] rgb,
  output logic          locked,
  output logic          underflow,
  output logic          misalign
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int TW    = $clog2(DIV);

  localparam logic [HW-1:0] H_MAX   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VISL  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_MAX   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VISL  = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  typedef enum logic [1:0] {SEEK, WAIT_TOP, RUN} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [HW-1:0] h, h_nxt;
  logic [VW-1:0] v, v_nxt;
  logic          vis_nxt, origin_nxt, hs_nxt, vs_nxt;
  logic          rdy_en, push, pop, empty, full;
  logic [CD:0]   head;
  logic          head_start;
  logic [CD-1:0] head_rgb;
  logic [CD-1:0] pix_rgb;
  logic          set_uf, set_ma;

  // Holds si_ready low during reset and releases it on the first edge after.
  always_ff @(posedge clk) rdy_en <= !reset;

  assign si_ready   = rdy_en && !full;
  assign push       = si_valid && si_ready;
  assign head_start = head[0];
  assign head_rgb   = head[CD:1];
  assign locked     = (state == RUN);

  vga_stream_sink_fifo #(.W(CD + 1), .AW(FIFO_AW)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (si_data),
    .pop      (pop),
    .head_dat (head),
    .empty    (empty),
    .full     (full)
  );

  // Pixel tick divider.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Raster position the next tick moves to; every pixel decision is made against it
  // so the registered outputs line up with the position the counters land on.
  always_comb begin
    h_nxt = h + 1'b1;
    v_nxt = v;
    if (h == H_MAX) begin
      h_nxt = '0;
      v_nxt = (v == V_MAX) ? '0 : v + 1'b1;
    end
  end

  assign vis_nxt    = (h_nxt < H_VISL) && (v_nxt < V_VISL);
  assign origin_nxt = (h_nxt == '0) && (v_nxt == '0);
  assign hs_nxt     = !((h_nxt >= HS_BEG) && (h_nxt <= HS_END));
  assign vs_nxt     = !((v_nxt >= VS_BEG) && (v_nxt <= VS_END));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= SEEK;
    else       state <= state_nxt;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      SEEK:     if (!empty && head_start) state_nxt = WAIT_TOP;
      WAIT_TOP: if (tick && origin_nxt)   state_nxt = RUN;
      RUN:      if (tick && vis_nxt && (empty || (head_start != origin_nxt))) state_nxt = SEEK;
      default:  state_nxt = SEEK;
    endcase
  end

  // FSM outputs: FIFO pop, pixel colour for the coming tick, error set strobes.
  // WAIT_TOP is only entered with a start word at the head, so its pop is never on empty.
  always_comb begin
    pop     = 1'b0;
    pix_rgb = '0;
    set_uf  = 1'b0;
    set_ma  = 1'b0;
    case (state)
      SEEK: pop = !empty && !head_start;
      WAIT_TOP: begin
        if (tick && origin_nxt) begin
          pop     = 1'b1;
          pix_rgb = head_rgb;
        end
      end
      RUN: begin
        if (tick && vis_nxt) begin
          if (empty) begin
            set_uf = 1'b1;
          end else if (head_start != origin_nxt) begin
            // A stray start word stays at the head so SEEK can relock on it directly.
            set_ma = 1'b1;
            pop    = !head_start;
          end else begin
            pop     = 1'b1;
            pix_rgb = head_rgb;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h     <= '0;
      v     <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else if (tick) begin
      h     <= h_nxt;
      v     <= v_nxt;
      hsync <= hs_nxt;
      vsync <= vs_nxt;
      rgb   <= pix_rgb;
    end
  end

  // Sticky flags: a new error wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      if (set_uf)       underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
      if (set_ma)       misalign  <= 1'b1;
      else if (err_clr) misalign  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vga_stream_sink.sv
module tb_vga_stream_sink;
  localparam int CD = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, si_valid, err_clr;
  logic [CD:0]   si_data;
  logic          si_ready, hsync, vsync, locked, underflow, misalign;
  logic [CD-1:0] rgb;

  logic [CD:0]   f_dat;
  logic          f_zero;
  logic          f_ready, f_hs, f_vs, f_locked, f_uf, f_ma;
  logic [CD-1:0] f_rgb;

  // Shrunk raster: 16 ticks per line (sync h=10..12), 10 lines per frame (sync v=6..7),
  // 8x4 visible, one frame = 160 ticks = 640 clks.
  vga_stream_sink #(
    .CD(CD), .DIV(4), .FIFO_AW(4),
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk(clk), .reset(reset), .si_data(si_data), .si_valid(si_valid), .si_ready(si_ready),
    .err_clr(err_clr), .hsync(hsync), .vsync(vsync), .rgb(rgb), .locked(locked),
    .underflow(underflow), .misalign(misalign)
  );

  // Full 640x480 geometry, idle stream: used for line-level sync timing.
  vga_stream_sink dut_full (
    .clk(clk), .reset(reset), .si_data(f_dat), .si_valid(f_zero), .si_ready(f_ready),
    .err_clr(f_zero), .hsync(f_hs), .vsync(f_vs), .rgb(f_rgb), .locked(f_locked),
    .underflow(f_uf), .misalign(f_ma)
  );

  typedef struct {
    logic          start;   // input frame_start bit
    logic [CD-1:0] rgb;     // input colour, and expected rgb when displayed
    int            gate_t;  // not offered before this many ticks have elapsed
    int            disp_t;  // tick after which it is on rgb with locked=1; -1 = discarded
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  function automatic void add(input logic s, input logic [CD-1:0] c, input int g, input int d);
    vec_t x;
    x.start  = s;
    x.rgb    = c;
    x.gate_t = g;
    x.disp_t = d;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  int            wi, t, h, v, f_low, f_first;
  logic [CD-1:0] er;
  logic          el, f_bad;
  bit            fire;

  initial begin
    // Junk before the first frame_start: discarded one per clk in SEEK.
    for (int i = 0; i < 3; i++) add(1'b0, CD'(32'h111 * (i + 1)), 0, -1);
    // Frame 1 (origin tick 160): 20 words, stream then stops -> underflow at (4,2), tick 196.
    for (int i = 0; i < 20; i++)
      add(i == 0, (i == 0) ? 12'hF00 : CD'(32'h100 + i), 0, 160 + 16 * (i / 8) + i % 8);
    // Frame 2 (origin tick 320), offered after the underflow is cleared; start word at (5,1) -> misalign.
    for (int j = 0; j < 13; j++)
      add(j == 0, (j == 0) ? 12'h0F0 : CD'(32'h200 + j), 201, 320 + 16 * (j / 8) + j % 8);
    // The stray start word is kept and becomes pixel (0,0) of frame 3 (tick 480).
    add(1'b1, 12'h00F, 201, 480);
    for (int p = 1; p < 32; p++)
      add(1'b0, CD'(32'h300 + p), 201, 480 + 16 * (p / 8) + p % 8);
    // start=0 at the frame 4 origin (tick 640) -> misalign, word dropped.
    add(1'b0, 12'hABC, 201, -1);

    f_dat = '0;
    f_zero = 1'b0;
    f_low = 0;
    f_first = -1;
    f_bad = 1'b0;
    wi = 0;

    reset = 1'b1;
    err_clr = 1'b0;
    si_valid = 1'b1;
    si_data = {12'h111, 1'b0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(si_ready), 32'd0);
    check("reset_sync", 32'({hsync, vsync}), 32'b11);
    check("reset_rgb", 32'(rgb), 32'd0);
    check("reset_flags", 32'({locked, underflow, misalign}), 32'b000);
    reset = 1'b0;

    while (cyc < 3204) begin
      si_valid = 1'b0;
      si_data = '0;
      if (wi < vecs.size()) begin
        if (cyc / 4 >= vecs[wi].gate_t) begin
          si_valid = 1'b1;
          si_data = {vecs[wi].rgb, vecs[wi].start};
        end
      end
      err_clr = (cyc + 1 == 801) || (cyc + 1 == 1381);
      fire = si_valid && si_ready;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (fire) wi++;

      if (cyc % 4 == 0) begin
        t = cyc / 4;
        h = t % 16;
        v = (t / 16) % 10;
        er = '0;
        el = 1'b0;
        for (int k = 0; k < vecs.size(); k++) begin
          if (vecs[k].disp_t == t) begin
            er = vecs[k].rgb;
            el = 1'b1;
          end
        end
        check("raster_hs_vs_rgb", 32'({hsync, vsync, rgb}), 32'({h < 10 || h > 12, v < 6 || v > 7, er}));
        if (el) check("locked_on_pixel", 32'(locked), 32'd1);
        if (t < 800) begin
          if (!f_hs) begin
            if (f_low == 0) f_first = t;
            f_low++;
          end
          if (f_rgb != '0 || !f_vs) f_bad = 1'b1;
        end
      end

      case (cyc)
        1:    check("ready_after_reset", 32'(si_ready), 32'd1);
        19:   check("bp_15_words_ready", 32'(si_ready), 32'd1);
        20:   check("bp_16_words_full", 32'(si_ready), 32'd0);
        639:  check("wait_top_hold", 32'({si_ready, locked}), 32'b00);
        640:  check("bp_pop_frees", 32'(si_ready), 32'd1);
        784:  check("underflow_set", 32'({locked, underflow, misalign}), 32'b010);
        801:  check("underflow_clr", 32'(underflow), 32'd0);
        1364: check("misalign_start1", 32'({locked, underflow, misalign}), 32'b001);
        1381: check("misalign_clr", 32'(misalign), 32'd0);
        2560: check("misalign_start0", 32'({locked, underflow, misalign}), 32'b001);
        3200: begin
          check("full_hsync_width", 32'(f_low), 32'd96);
          check("full_hsync_start", 32'(f_first), 32'd656);
          check("full_line0_vs_rgb", 32'(f_bad), 32'd0);
        end
        default: ;
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_stream_sink.md
# vga_stream_sink

Single-clock consumer end of the video daisy-chain pixel stream. Accepts `{rgb, frame_start}` words over a valid/ready handshake into a small FIFO. Aligns the stream to a free-running 640x480 VGA raster and drives registered hsync/vsync/rgb. It replaces the dual-clock sync core in builds where the pixel rate is derived from the system clock by a tick divider.

## Interface
- `CD`, 12, colour depth in bits.
- `DIV`, 4, system clocks per pixel; the pixel tick fires every DIV cycles. Must be ≥ 2.
- `FIFO_AW`, 4, FIFO address width; depth = 2^FIFO_AW words.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `si_data`  in  CD+1  stream word; [CD:1] = rgb, [0] = frame_start (first visible pixel of a frame).
- `si_valid`  in  1  producer has a word on si_data.
- `si_ready`  out  1  sink can accept a word.
- `err_clr`  in  1  clears the sticky error flags.
- `hsync`  out  1  horizontal sync, active-low.
- `vsync`  out  1  vertical sync, active-low.
- `rgb`  out  CD  pixel colour; 0 outside the visible area.
- `locked`  out  1  high while in RUN.
- `underflow`  out  1  sticky: the FIFO was empty when a visible pixel was due.
- `misalign`  out  1  sticky: a frame_start bit was inconsistent with the raster position.

## Operation
- **Handshake:** a transfer occurs on a rising edge with si_valid && si_ready. si_ready = !full, derived from the registered count. The producer may hold si_valid indefinitely. The word is written at the FIFO tail on the same edge.
- **FIFO:** depth 2^FIFO_AW with a (FIFO_AW+1)-bit count. A simultaneous push and pop leaves count unchanged. A pop on empty is never issued. Pointers wrap modulo depth.
- **Tick divider:** tick_cnt runs 0..DIV-1; `tick` = (tick_cnt == DIV-1).
- **Raster counters:** h runs 0..799 and v runs 0..524, both advancing on tick. h wraps to 0 and increments v; v wraps at 524. The counters free-run from reset regardless of state.
  - Visible: h<640 && v<480.
  - hsync low for h in 656..751.
  - vsync low for v in 490..491.
- **FSM (states SEEK, WAIT_TOP, RUN; reset → SEEK):**
  - SEEK: while the FIFO head has start=0, pop one word per clk (discard). When the head has start=1, go to WAIT_TOP without popping.
  - WAIT_TOP: hold the head. On the tick where the next raster position is (0,0), pop the head as pixel (0,0) and go to RUN.
  - RUN: on each tick entering a visible position, pop the head as that pixel's rgb. Two error cases, both handled within the same tick:
    - Popped word has start=1 at a position ≠ (0,0), or start=0 at (0,0): set misalign, output rgb=0 for that pixel, go to SEEK. A start=1 word is not discarded; it is kept at the head.
    - FIFO empty when a visible pixel is due: set underflow, output rgb=0, go to SEEK.
  - Non-visible positions never pop.
- **Error flags:** set has priority over err_clr in the same cycle. Otherwise err_clr clears both flags on the next edge.

## Timing
- **Reset values:** hsync=1, vsync=1, rgb=0, locked=0, underflow=0, misalign=0, FIFO empty, h=v=tick_cnt=0. si_ready is 0 while reset is high and 1 on the first cycle after reset.
- **Output registering:** hsync, vsync and rgb are registered and update only on tick edges. After the tick edge that advances to position (h,v), the outputs reflect (h,v).
- **Push-to-display latency:** at least 1 clk from a push to visibility at the FIFO head. A word pushed on the edge before a tick is eligible for pop at that tick.
- **Throughput:** the sink drains at most one word per DIV clocks in RUN and one per clk in SEEK.
- **Reset mid-frame:** any in-flight data is discarded, the FIFO is emptied, and the FSM returns to SEEK. The producer must restart at a frame_start word.

## Test plan
- **Reset:** assert reset for 3 clks with si_valid=1 → si_ready=0, hsync=vsync=1, rgb=0, all flags 0; si_ready=1 one clk after reset drops.
- **Backpressure:** FIFO_AW=4, with the FSM held in WAIT_TOP by a first word with start=1, push 16 words → si_ready falls after the 16th accepted word and the 17th is not accepted. Pop one → si_ready returns high the next clk.
- **Lock:** send 3 words with start=0, then a frame stream beginning with start=1 and rgb=12'hF00 → the 3 words are discarded in 3 clks; locked rises at the (0,0) tick; rgb=12'hF00 during pixel (0,0); pixel (1,0) shows the next word.
- **Sync timing:** with locked, count ticks → hsync low for exactly 96 ticks starting at h=656; vsync low for 2 lines starting at v=490; rgb=0 at h=640..799.
- **Underflow:** stop si_valid mid-line at v=10, h=200 → underflow=1, rgb=0, locked=0. Pulse err_clr → underflow=0 on the next clk.
- **Misalign:** inject a start=1 word at pixel (100,5) → misalign=1, state SEEK. Relock at the next frame origin with a correct first pixel.
